// File: rtl/audio_sample_player.sv
// rtl/audio_sample_player.sv - paced sample-memory reader with volume scaling for the PWM stage
module audio_sample_player #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int SAMPLE_HZ   = 8_000,
  parameter int ADDR_W      = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [4:0]        volume,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_data,
  output logic [7:0]        music_data,
  output logic              playing,
  output logic              sample_tick,
  output logic              done
);

  localparam int DIV   = CLK_HZ / SAMPLE_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [2:0] {IDLE, WAIT_TICK, READ, WAIT_DATA, FINISH} state_t;

  state_t            state, next_state;
  logic [CNT_W-1:0]  tick_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic [ADDR_W-1:0] cur_addr, start_lat, end_lat;
  logic [7:0]        cap_data;
  logic [4:0]        cap_vol;
  logic              pending;
  logic              capture, at_end, finish_tick;
  logic signed [8:0]  delta;
  logic signed [14:0] prod, scaled;
  logic [7:0]        scaled_sample;

  // Next state and combinational outputs; stop outranks start, start outranks the walk
  always_comb begin
    next_state  = state;
    playing     = (state != IDLE);
    sample_tick = playing && (tick_cnt == CNT_W'(DIV - 1));
    mem_rd_en   = (state == READ);
    mem_addr    = (state == READ) ? cur_addr : '0;
    capture     = (state == WAIT_DATA) && (lat_cnt == LAT_W'(MEM_LATENCY - 1));
    at_end      = (cur_addr == end_lat);
    finish_tick = (state == FINISH) && sample_tick;
    if (stop) begin
      next_state = IDLE;
    end else if (start) begin
      next_state = WAIT_TICK;
    end else begin
      case (state)
        IDLE:      next_state = IDLE;
        WAIT_TICK: if (sample_tick) next_state = READ;
        READ:      next_state = WAIT_DATA;
        WAIT_DATA: if (capture) next_state = (at_end && !loop_en) ? FINISH : WAIT_TICK;
        FINISH:    if (sample_tick) next_state = IDLE;
        default:   next_state = IDLE;
      endcase
    end
  end

  // Offset-binary gain: 128 + floor((sample-128)*v/16); bit 7 flip re-adds the mid-scale offset
  always_comb begin
    delta         = $signed({1'b0, cap_data}) - 9'sd128;
    prod          = $signed({{6{delta[8]}}, delta}) * $signed({10'b0, cap_vol});
    scaled        = prod >>> 4;
    scaled_sample = scaled[7:0] ^ 8'h80;
  end

  // State, pacing counter, address walk, capture and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      lat_cnt    <= '0;
      cur_addr   <= '0;
      start_lat  <= '0;
      end_lat    <= '0;
      cap_data   <= 8'd128;
      cap_vol    <= 5'd0;
      pending    <= 1'b0;
      music_data <= 8'd128;
      done       <= 1'b0;
    end else begin
      state <= next_state;
      done  <= 1'b0;

      if (stop || start || !playing || finish_tick)
        tick_cnt <= '0;
      else if (tick_cnt == CNT_W'(DIV - 1))
        tick_cnt <= '0;
      else
        tick_cnt <= tick_cnt + 1'b1;

      if (state == READ)
        lat_cnt <= '0;
      else if (state == WAIT_DATA)
        lat_cnt <= lat_cnt + 1'b1;

      if (stop) begin
        // Abandon any read in flight; the PWM goes straight to silence
        pending    <= 1'b0;
        music_data <= 8'd128;
      end else if (start) begin
        start_lat <= start_addr;
        end_lat   <= end_addr;
        cur_addr  <= start_addr;
        pending   <= 1'b0;
      end else begin
        if (capture) begin
          cap_data <= mem_data;
          cap_vol  <= (volume > 5'd16) ? 5'd16 : volume;
          pending  <= 1'b1;
          if (!at_end)
            cur_addr <= cur_addr + 1'b1;
          else if (loop_en)
            cur_addr <= start_lat;
        end
        if (finish_tick) begin
          music_data <= 8'd128;
          done       <= 1'b1;
        end else if (pending) begin
          music_data <= scaled_sample;
          pending    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_sample_player.sv
// tb/tb_audio_sample_player.sv - directed checks of pacing, range walk, looping, gain and pulses
module tb_audio_sample_player;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              reset, start, stop, loop_en;
  logic [ADDR_W-1:0] start_addr, end_addr;
  logic [4:0]        volume;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [7:0]        mem_data;
  logic [7:0]        music_data;
  logic              playing, sample_tick, done;
  logic [7:0]        mem_s1, mem_s2;

  int tests_run = 0;
  int tests_failed = 0;

  audio_sample_player #(
    .CLK_HZ(100), .SAMPLE_HZ(10), .ADDR_W(ADDR_W), .MEM_LATENCY(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .start_addr(start_addr), .end_addr(end_addr), .volume(volume),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_data(mem_data),
    .music_data(music_data), .playing(playing), .sample_tick(sample_tick), .done(done)
  );

  always #5 clk = ~clk;

  // Two-stage synchronous-read memory: mem[a] = a[7:0] + 100
  always @(posedge clk) begin
    mem_s1 <= mem_rd_en ? (mem_addr[7:0] + 8'd100) : mem_s1;
    mem_s2 <= mem_s1;
  end
  assign mem_data = mem_s2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic play_one(input logic [15:0] a, input logic [4:0] v, input logic [7:0] exp, input string tag);
    int seen;
    start_addr = a; end_addr = a; loop_en = 1'b0; volume = v;
    pulse_start();
    repeat (14) step();
    check(tag, music_data, exp);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      step();
      if (done) seen = 1;
    end
    check({tag, "_done"}, seen, 1);
  endtask

  initial begin
    int dc, at, nrd, first_rd;
    logic [15:0] rd_addr [0:7];

    reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    start_addr = '0; end_addr = '0; volume = 5'd16;
    repeat (3) step();
    check("rst_music", music_data, 128);
    check("rst_addr", mem_addr, 0);
    check("rst_rden", mem_rd_en, 0);
    check("rst_play", playing, 0);
    check("rst_tick", sample_tick, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    step();

    // Non-looping clip 4..6 at full volume
    start_addr = 16'd4; end_addr = 16'd6; loop_en = 1'b0; volume = 5'd16;
    pulse_start();
    repeat (13) step();
    check("clip_before_first", music_data, 128);
    step();
    check("clip_s0", music_data, 104);
    check("clip_playing", playing, 1);
    repeat (9) step();
    check("clip_s0_hold", music_data, 104);
    step();
    check("clip_s1", music_data, 105);
    repeat (10) step();
    check("clip_s2", music_data, 106);
    dc = 0; at = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 5) check("clip_s2_hold", music_data, 106);
      if (done) begin dc++; at = i; end
      if (i == 6) begin
        check("clip_end_music", music_data, 128);
        check("clip_end_play", playing, 0);
      end
    end
    check("clip_done_count", dc, 1);
    check("clip_done_at", at, 6);

    // Looping clip
    loop_en = 1'b1;
    pulse_start();
    dc = 0;
    for (int i = 1; i <= 54; i++) begin
      step();
      if (done) dc++;
      case (i)
        14: check("loop_s0", music_data, 104);
        24: check("loop_s1", music_data, 105);
        34: check("loop_s2", music_data, 106);
        44: check("loop_s3", music_data, 104);
        54: check("loop_s4", music_data, 105);
        default: ;
      endcase
    end
    check("loop_no_done", dc, 0);
    pulse_stop();
    check("stop_music", music_data, 128);
    check("stop_play", playing, 0);
    step();

    // Gain
    play_one(16'd128, 5'd8,  8'd178, "vol8_pos");
    play_one(16'd128, 5'd0,  8'd128, "vol0");
    play_one(16'd128, 5'd31, 8'd228, "vol31_clamp");
    play_one(16'd184, 5'd8,  8'd78,  "vol8_neg");

    // Address wrap through the top of memory
    start_addr = 16'hFFFE; end_addr = 16'h0001; loop_en = 1'b0; volume = 5'd16;
    pulse_start();
    nrd = 0; dc = 0;
    for (int i = 1; i <= 60 && dc == 0; i++) begin
      if (mem_rd_en && nrd < 8) begin rd_addr[nrd] = mem_addr; nrd++; end
      step();
      if (done) dc = 1;
    end
    check("wrap_reads", nrd, 4);
    check("wrap_a0", rd_addr[0], 16'hFFFE);
    check("wrap_a1", rd_addr[1], 16'hFFFF);
    check("wrap_a2", rd_addr[2], 16'h0000);
    check("wrap_a3", rd_addr[3], 16'h0001);
    check("wrap_done", dc, 1);

    // start and stop together from IDLE
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("startstop_play", playing, 0);
    nrd = 0;
    for (int i = 0; i < 15; i++) begin step(); if (mem_rd_en) nrd++; end
    check("startstop_reads", nrd, 0);
    check("startstop_play2", playing, 0);

    // Restart mid-playback
    start_addr = 16'd4; end_addr = 16'd6; loop_en = 1'b1;
    pulse_start();
    repeat (25) step();
    start_addr = 16'd10; end_addr = 16'd12;
    pulse_start();
    first_rd = -1; at = 0;
    for (int i = 0; i < 20 && first_rd < 0; i++) begin
      if (mem_rd_en) begin first_rd = i; at = mem_addr; end
      step();
    end
    check("restart_rd_cycle", first_rd, 10);
    check("restart_rd_addr", at, 10);
    repeat (4) step();
    check("restart_music", music_data, 110);
    pulse_stop();

    // Reset while a read is in flight
    start_addr = 16'd4; end_addr = 16'd6; loop_en = 1'b1;
    pulse_start();
    repeat (12) step();
    check("midrd_state", playing, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_music", music_data, 128);
    check("midrst_play", playing, 0);
    check("midrst_rden", mem_rd_en, 0);
    nrd = 0; dc = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (mem_rd_en) nrd++;
      if (music_data != 8'd128) dc++;
    end
    check("midrst_no_reads", nrd, 0);
    check("midrst_silent", dc, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
